serial_bus_rr: RTL

SERIAL_BUS_RR -- requirements
Module: serial_bus_rr

---
 rtl/serial_bus_rr.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_bus_rr.sv
`default_nettype none
// ============================================================================
// Module   : serial_bus_rr
// Purpose  : Round-robin arbiter that connects one of several serial masters
//            to a slave chosen by a serially shifted slave-select field.
// Revision : 1.0 - initial release
// ============================================================================

module serial_bus_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_BITS    = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_MASTERS-1:0] m_breq,
    input  logic [NUM_MASTERS-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0] m_wvalid,
    input  logic [NUM_MASTERS-1:0] m_mode,
    output logic [NUM_MASTERS-1:0] m_bgrant,
    output logic [NUM_MASTERS-1:0] m_ack,
    output logic [NUM_MASTERS-1:0] m_nack,
    output logic [NUM_MASTERS-1:0] m_timeout,
    output logic [NUM_MASTERS-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0] m_rvalid,
    output logic                   s_wdata,
    output logic                   s_mode,
    output logic [NUM_SLAVES-1:0]  s_wvalid,
    input  logic [NUM_SLAVES-1:0]  s_rdata,
    input  logic [NUM_SLAVES-1:0]  s_rvalid,
    input  logic [NUM_SLAVES-1:0]  s_ready,
    output logic [SEL_BITS-1:0]    ssel,
    output logic                   bus_busy
);

    localparam int          c_midx_w  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int          c_cand_w  = c_midx_w + 1;
    localparam int          c_bcnt_w  = $clog2(SEL_BITS + 1);
    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DECODE  = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_midx_w-1:0]    r_gidx;
    logic [c_midx_w-1:0]    r_last;
    logic [c_midx_w-1:0]    w_win;
    logic [c_midx_w-1:0]    w_gidx_nxt;
    logic [c_cand_w-1:0]    w_cand;
    logic                   w_found;

    logic [SEL_BITS-1:0]    r_sel;
    logic [SEL_BITS-1:0]    r_ssel;
    logic [SEL_BITS-1:0]    w_sel_shift;
    logic [c_bcnt_w-1:0]    r_bcnt;
    logic [15:0]            r_cnt;
    logic [15:0]            w_cnt_inc;

    logic [NUM_MASTERS-1:0] r_bgrant;
    logic [NUM_MASTERS-1:0] r_ack;
    logic [NUM_MASTERS-1:0] r_nack;
    logic [NUM_MASTERS-1:0] r_tmo;
    logic [NUM_MASTERS-1:0] w_g_onehot;
    logic [NUM_MASTERS-1:0] w_nxt_onehot;

    logic                   w_g_breq;
    logic                   w_g_wvalid;
    logic                   w_g_wdata;
    logic                   w_g_mode;
    logic                   w_s_rdata;
    logic                   w_s_rvalid;
    logic                   w_sel_ok;
    logic                   w_last_bit;
    logic                   w_activity;
    logic                   w_xfer;

    logic                   w_grant;
    logic                   w_shift;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_tmo;

    // Signals of the currently granted master
    always_comb begin
        w_g_breq   = 1'b0;
        w_g_wvalid = 1'b0;
        w_g_wdata  = 1'b0;
        w_g_mode   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_gidx == c_midx_w'(i)) begin
                w_g_breq   = m_breq[i];
                w_g_wvalid = m_wvalid[i];
                w_g_wdata  = m_wdata[i];
                w_g_mode   = m_mode[i];
            end
        end
    end

    // Signals of the selected slave
    always_comb begin
        w_s_rdata  = 1'b0;
        w_s_rvalid = 1'b0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (r_ssel == SEL_BITS'(j)) begin
                w_s_rdata  = s_rdata[j];
                w_s_rvalid = s_rvalid[j];
            end
        end
    end

    // Out-of-range indices never match a slave, so they naturally decode as not ready
    assign w_sel_shift = SEL_BITS'({r_sel, w_g_wdata});
    assign w_last_bit  = (r_bcnt == c_bcnt_w'(SEL_BITS - 1));

    always_comb begin
        w_sel_ok = 1'b0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (w_sel_shift == SEL_BITS'(j)) begin
                w_sel_ok = s_ready[j];
            end
        end
    end

    // Round-robin search starting one past the previous owner
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = {1'b0, r_last} + c_cand_w'(i);
            if (w_cand >= c_cand_w'(NUM_MASTERS)) begin
                w_cand = w_cand - c_cand_w'(NUM_MASTERS);
            end
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!w_found && (w_cand == c_cand_w'(k)) && m_breq[k]) begin
                    w_found = 1'b1;
                    w_win   = c_midx_w'(k);
                end
            end
        end
    end

    assign w_activity = w_g_wvalid | w_s_rvalid;
    assign w_cnt_inc  = r_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_shift     = 1'b0;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!w_g_breq) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_g_wvalid) begin
                    w_shift = 1'b1;
                    if (w_last_bit) begin
                        if (w_sel_ok) begin
                            w_accept    = 1'b1;
                            w_state_nxt = ST_ACTIVE;
                        end else begin
                            w_reject    = 1'b1;
                            w_state_nxt = ST_RELEASE;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                // A request drop wins over a coincident timeout
                if (!w_g_breq) begin
                    w_state_nxt = ST_RELEASE;
                end else if (!w_activity && (w_cnt_inc == c_timeout)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_gidx_nxt = w_grant ? w_win : r_gidx;

    always_comb begin
        w_g_onehot   = '0;
        w_nxt_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_g_onehot[i]   = (r_gidx == c_midx_w'(i));
            w_nxt_onehot[i] = (w_gidx_nxt == c_midx_w'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_gidx   <= '0;
            r_last   <= c_midx_w'(NUM_MASTERS - 1);
            r_sel    <= '0;
            r_bcnt   <= '0;
            r_ssel   <= '0;
            r_cnt    <= '0;
            r_bgrant <= '0;
            r_ack    <= '0;
            r_nack   <= '0;
            r_tmo    <= '0;
        end else begin
            r_ack  <= w_accept ? w_g_onehot : '0;
            r_nack <= w_reject ? w_g_onehot : '0;
            r_tmo  <= w_tmo    ? w_g_onehot : '0;

            if (w_grant) begin
                r_gidx <= w_win;
                r_sel  <= '0;
                r_bcnt <= '0;
            end else if (w_shift) begin
                r_sel  <= w_sel_shift;
                r_bcnt <= r_bcnt + c_bcnt_w'(1);
            end

            if (w_accept) begin
                r_ssel <= w_sel_shift;
                r_cnt  <= '0;
            end else if (r_state == ST_ACTIVE) begin
                r_cnt  <= w_activity ? 16'd0 : w_cnt_inc;
            end

            if (w_state_nxt == ST_RELEASE) begin
                r_last <= r_gidx;
            end

            if ((w_state_nxt == ST_DECODE) || (w_state_nxt == ST_ACTIVE)) begin
                r_bgrant <= w_nxt_onehot;
            end else begin
                r_bgrant <= '0;
            end
        end
    end

    assign w_xfer    = (r_state == ST_DECODE) || (r_state == ST_ACTIVE);
    assign s_wdata   = w_xfer & w_g_wdata;
    assign s_mode    = w_xfer & w_g_mode;
    assign bus_busy  = (r_state != ST_IDLE);
    assign ssel      = r_ssel;
    assign m_bgrant  = r_bgrant;
    assign m_ack     = r_ack;
    assign m_nack    = r_nack;
    assign m_timeout = r_tmo;

    always_comb begin
        s_wvalid = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            s_wvalid[j] = (r_state == ST_ACTIVE) && (r_ssel == SEL_BITS'(j)) && w_g_wvalid;
        end
    end

    always_comb begin
        m_rdata  = '0;
        m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rdata[i]  = (r_state == ST_ACTIVE) && w_g_onehot[i] && w_s_rdata;
            m_rvalid[i] = (r_state == ST_ACTIVE) && w_g_onehot[i] && w_s_rvalid;
        end
    end

endmodule

`default_nettype wire
